// File: rtl/frame_reader_if.sv
// Memory read bus plus pixel stream of frame_reader, bundled so that the reader
// (master) and the memory/consumer side (slave) share one connection.
interface frame_reader_if #(
    parameter int WD = 8,
    parameter int AW = 17
);
    logic          cs;
    logic          we;
    logic [AW-1:0] addr;
    logic [WD-1:0] mem_dout;
    logic          m_valid;
    logic          m_ready;
    logic [WD-1:0] m_data;
    logic          m_eol;
    logic          m_eof;

    modport master (
        output cs, we, addr, m_valid, m_data, m_eol, m_eof,
        input  mem_dout, m_ready
    );

    modport slave (
        input  cs, we, addr, m_valid, m_data, m_eol, m_eof,
        output mem_dout, m_ready
    );
endinterface

// File: rtl/frame_reader.sv
// Streams an IMG_W x IMG_H frame out of the single-port image buffer in raster
// order. Reads are credit-limited so the output skid FIFO can never overflow.
module frame_reader #(
    parameter int WD         = 8,
    parameter int AW         = 17,
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int BASE       = 65536,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          finish,
    output logic [1:0]    o_dbg_state,
    frame_reader_if.master bus
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] BASE_A = AW'(BASE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic [AW-1:0]  r_addr;
    logic           r_inflight;
    logic [1:0]     r_tag;
    logic [WD-1:0]  r_fifo_data [FIFO_DEPTH];
    logic [1:0]     r_fifo_tag  [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic w_credit;
    logic w_issue;
    logic w_eol;
    logic w_eof;
    logic w_push;
    logic w_pop;
    logic w_valid;

    // A read is only issued when the FIFO has room for it and for the read already in flight.
    assign w_credit = (r_count + CW'(r_inflight)) < CW'(FIFO_DEPTH);
    assign w_issue  = (r_state == S_READ) && w_credit;
    assign w_eol    = (r_x == XW'(IMG_W - 1));
    assign w_eof    = w_eol && (r_y == YW'(IMG_H - 1));
    assign w_push   = r_inflight;
    assign w_valid  = (r_count != '0);
    // Stream handshake: a beat moves on any cycle with m_valid && m_ready; while
    // m_valid is high and m_ready low, m_data/m_eol/m_eof are held unchanged.
    assign w_pop    = w_valid && bus.m_ready;

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_READ;
            end
            S_READ: begin
                busy = 1'b1;
                if (w_issue && w_eof) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_count == '0 && !r_inflight) w_next = S_DONE;
            end
            S_DONE: begin
                finish = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_addr     <= BASE_A;
            r_inflight <= 1'b0;
            r_tag      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_issue;
            r_tag      <= {w_eof, w_eol};
            if (r_state == S_IDLE && start) begin
                r_x    <= '0;
                r_y    <= '0;
                r_addr <= BASE_A;
            end else if (w_issue) begin
                // Raster order is contiguous in memory, so the address just counts up.
                r_addr <= r_addr + AW'(1);
                if (w_eol) begin
                    r_x <= '0;
                    r_y <= w_eof ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bus.mem_dout;
            r_fifo_tag[r_wr_ptr]  <= r_tag;
        end
    end

    assign bus.cs      = w_issue;
    assign bus.we      = 1'b0;
    assign bus.addr    = w_issue ? r_addr : '0;
    assign bus.m_valid = w_valid;
    assign bus.m_data  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign bus.m_eol   = w_valid && r_fifo_tag[r_rd_ptr][0];
    assign bus.m_eof   = w_valid && r_fifo_tag[r_rd_ptr][1];
    assign o_dbg_state = r_state;
endmodule
